// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store queue: allocate, fill, commit, drain to memory
// Optional store-to-load forwarding compiled in with STORE_FORWARD_EN.
module store_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alloc_valid,
  input  logic [4:0]  _alloc_rob_id,
  input  logic [1:0]  _alloc_width,
  input  logic        _lsb_rs_ready,
  input  logic [4:0]  _lsb_rob_id,
  input  logic [31:0] _lsb_st_value,
  input  logic [31:0] _lsb_ptr_value,
  input  logic        _commit_valid,
  input  logic [4:0]  _commit_rob_id,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  output logic [31:0] _mem_data,
  output logic [1:0]  _mem_width,
  input  logic        _mem_done,
  output logic        _sb_full,
  output logic        _sb_empty
`ifdef STORE_FORWARD_EN
  ,
  input  logic [31:0] _fwd_addr,
  output logic        _fwd_hit,
  output logic [31:0] _fwd_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {E_INV, E_WAIT, E_FILL, E_COMM} ent_state_t;
  typedef enum logic {S_IDLE, S_BUSY} fsm_t;

  ent_state_t  ent_state [DEPTH];
  logic [4:0]  ent_rob   [DEPTH];
  logic [1:0]  ent_width [DEPTH];
  logic [31:0] ent_addr  [DEPTH];
  logic [31:0] ent_data  [DEPTH];

  logic [PTR_W-1:0] head, cptr, tail;
  logic [CNT_W-1:0] count, com_count;
  fsm_t             state, state_next;

  logic             do_alloc, do_fill, do_commit, do_start, do_pop, do_clear;
  logic [DEPTH-1:0] fill_hit;

  assign _sb_full  = (count == FULL_CNT);
  assign _sb_empty = (count == '0);

  // Everything is gated by rdy_in so a low rdy_in freezes all state.
  always_comb begin
    do_clear  = rdy_in && _clear;
    do_alloc  = rdy_in && !_clear && _alloc_valid && !_sb_full;
    do_fill   = rdy_in && !_clear && _lsb_rs_ready;
    do_commit = rdy_in && !_clear && _commit_valid &&
                (ent_state[cptr] == E_FILL) && (ent_rob[cptr] == _commit_rob_id);
    for (int i = 0; i < DEPTH; i++) begin
      fill_hit[i] = do_fill && (ent_state[i] == E_WAIT) && (ent_rob[i] == _lsb_rob_id);
    end
  end

  always_comb begin
    state_next = state;
    do_start   = 1'b0;
    do_pop     = 1'b0;
    if (rdy_in) begin
      case (state)
        S_IDLE: begin
          if (ent_state[head] == E_COMM) begin
            do_start   = 1'b1;
            state_next = S_BUSY;
          end
        end
        S_BUSY: begin
          if (_mem_done) begin
            do_pop     = 1'b1;
            state_next = S_IDLE;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      _mem_req   <= 1'b0;
      _mem_addr  <= '0;
      _mem_data  <= '0;
      _mem_width <= '0;
    end else if (do_start) begin
      _mem_req   <= 1'b1;
      _mem_addr  <= ent_addr[head];
      _mem_data  <= ent_data[head];
      _mem_width <= ent_width[head];
    end else if (do_pop) begin
      _mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head      <= '0;
      cptr      <= '0;
      tail      <= '0;
      count     <= '0;
      com_count <= '0;
    end else begin
      if (do_pop)    head <= head + PTR_W'(1);
      if (do_commit) cptr <= cptr + PTR_W'(1);
      // A flush truncates the queue back to the committed region.
      if (do_clear) begin
        tail  <= cptr;
        count <= com_count - CNT_W'(do_pop);
      end else begin
        if (do_alloc) tail <= tail + PTR_W'(1);
        count <= count + CNT_W'(do_alloc) - CNT_W'(do_pop);
      end
      com_count <= com_count + CNT_W'(do_commit) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) ent_state[i] <= E_INV;
    end else begin
      if (do_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (ent_state[i] == E_WAIT || ent_state[i] == E_FILL) ent_state[i] <= E_INV;
        end
      end
      if (do_alloc) ent_state[tail] <= E_WAIT;
      for (int i = 0; i < DEPTH; i++) begin
        if (fill_hit[i]) ent_state[i] <= E_FILL;
      end
      if (do_commit) ent_state[cptr] <= E_COMM;
      if (do_pop)    ent_state[head] <= E_INV;
    end
  end

  // Payload storage carries no reset; validity lives in ent_state.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      ent_rob[tail]   <= _alloc_rob_id;
      ent_width[tail] <= _alloc_width;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (fill_hit[i]) begin
        ent_addr[i] <= _lsb_ptr_value;
        ent_data[i] <= _lsb_st_value;
      end
    end
  end

`ifdef STORE_FORWARD_EN
  logic unused_fwd_lo;
  assign unused_fwd_lo = ^_fwd_addr[1:0];

  // Walk oldest to youngest so the youngest matching word store wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    _fwd_hit  = 1'b0;
    _fwd_data = '0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if ((ent_state[idx] == E_FILL || ent_state[idx] == E_COMM) &&
          (ent_width[idx] == 2'b10) &&
          (ent_addr[idx][31:2] == _fwd_addr[31:2])) begin
        _fwd_hit  = 1'b1;
        _fwd_data = ent_data[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
  localparam int DEPTH = 16;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, _clear;
  logic        _alloc_valid, _lsb_rs_ready, _commit_valid, _mem_done;
  logic [4:0]  _alloc_rob_id, _lsb_rob_id, _commit_rob_id;
  logic [1:0]  _alloc_width, _mem_width;
  logic [31:0] _lsb_st_value, _lsb_ptr_value, _mem_addr, _mem_data;
  logic        _mem_req, _sb_full, _sb_empty;
`ifdef STORE_FORWARD_EN
  logic [31:0] _fwd_addr, _fwd_data;
  logic        _fwd_hit;
`endif

  always #5 clk_in = ~clk_in;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), ._clear(_clear),
    ._alloc_valid(_alloc_valid), ._alloc_rob_id(_alloc_rob_id), ._alloc_width(_alloc_width),
    ._lsb_rs_ready(_lsb_rs_ready), ._lsb_rob_id(_lsb_rob_id),
    ._lsb_st_value(_lsb_st_value), ._lsb_ptr_value(_lsb_ptr_value),
    ._commit_valid(_commit_valid), ._commit_rob_id(_commit_rob_id),
    ._mem_req(_mem_req), ._mem_addr(_mem_addr), ._mem_data(_mem_data),
    ._mem_width(_mem_width), ._mem_done(_mem_done),
    ._sb_full(_sb_full), ._sb_empty(_sb_empty)
`ifdef STORE_FORWARD_EN
    , ._fwd_addr(_fwd_addr), ._fwd_hit(_fwd_hit), ._fwd_data(_fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  rob;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  rob;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] data;
    wr_t         expct;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         cur;
  vec_t        vecs[4];
  logic [31:0] mdl_addr[32];
  logic [31:0] mdl_data[32];
  logic [1:0]  mdl_width[32];
  int          checks = 0;
  int          errors = 0;
  logic        prev_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: each new request is popped against the expected write order.
  always @(negedge clk_in) begin
    if (_mem_req === 1'b1 && prev_req !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no request", _mem_addr, _mem_data);
      end else begin
        cur = exp_q.pop_front();
        check("mem_addr", _mem_addr, cur.addr);
        check("mem_data", _mem_data, cur.data);
        check("mem_width", {30'd0, _mem_width}, {30'd0, cur.width});
      end
    end else if (_mem_req === 1'b1) begin
      check("hold_addr", _mem_addr, cur.addr);
      check("hold_data", _mem_data, cur.data);
    end
    prev_req = _mem_req;
  end

  task automatic tick();
    @(negedge clk_in);
  endtask

  function automatic wr_t mk(input logic [4:0] r);
    wr_t w;
    w.rob = r; w.width = mdl_width[r]; w.addr = mdl_addr[r]; w.data = mdl_data[r];
    return w;
  endfunction

  task automatic alloc(input logic [4:0] rob, input logic [1:0] w);
    _alloc_valid = 1'b1; _alloc_rob_id = rob; _alloc_width = w; mdl_width[rob] = w;
    tick();
    _alloc_valid = 1'b0;
  endtask

  task automatic fill(input logic [4:0] rob, input logic [31:0] a, input logic [31:0] d);
    _lsb_rs_ready = 1'b1; _lsb_rob_id = rob; _lsb_ptr_value = a; _lsb_st_value = d;
    mdl_addr[rob] = a; mdl_data[rob] = d;
    tick();
    _lsb_rs_ready = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rob, input bit push, input wr_t e);
    _commit_valid = 1'b1; _commit_rob_id = rob;
    if (push) exp_q.push_back(e);
    tick();
    _commit_valid = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (_mem_req !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (_mem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got mem_req %b expected 1", _mem_req);
    end
  endtask

  task automatic serve();
    wait_req();
    if (_mem_req === 1'b1) begin
      tick(); tick();
      _mem_done = 1'b1;
      tick();
      _mem_done = 1'b0;
    end
  endtask

  initial begin
    vecs[0] = '{5'd7,  2'b00, 32'h0000_0010, 32'h0000_00A5, '{5'd7,  2'b00, 32'h0000_0010, 32'h0000_00A5}};
    vecs[1] = '{5'd8,  2'b01, 32'h0000_0022, 32'h0000_BEEF, '{5'd8,  2'b01, 32'h0000_0022, 32'h0000_BEEF}};
    vecs[2] = '{5'd9,  2'b10, 32'hFFFF_FFFC, 32'h1234_5678, '{5'd9,  2'b10, 32'hFFFF_FFFC, 32'h1234_5678}};
    vecs[3] = '{5'd31, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, '{5'd31, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF}};

    rst_in = 1'b1; rdy_in = 1'b1; _clear = 1'b0; _mem_done = 1'b0;
    _alloc_valid = 1'b0; _alloc_rob_id = '0; _alloc_width = '0;
    _lsb_rs_ready = 1'b0; _lsb_rob_id = '0; _lsb_st_value = '0; _lsb_ptr_value = '0;
    _commit_valid = 1'b0; _commit_rob_id = '0;
`ifdef STORE_FORWARD_EN
    _fwd_addr = '0;
`endif
    tick(); tick();
    rst_in = 1'b0;
    check("rst_req", {31'd0, _mem_req}, 32'd0);
    check("rst_addr", _mem_addr, 32'd0);
    check("rst_data", _mem_data, 32'd0);
    check("rst_width", {30'd0, _mem_width}, 32'd0);
    check("rst_full", {31'd0, _sb_full}, 32'd0);
    check("rst_empty", {31'd0, _sb_empty}, 32'd1);

    alloc(5'd3, 2'b10);
    fill(5'd3, 32'h100, 32'hDEAD_BEEF);
    commit(5'd3, 1'b1, mk(5'd3));
    serve();
    check("basic_req_low", {31'd0, _mem_req}, 32'd0);
    check("basic_empty", {31'd0, _sb_empty}, 32'd1);

    for (int i = 0; i < 4; i++) alloc(vecs[i].rob, vecs[i].width);
    for (int i = 3; i >= 0; i--) fill(vecs[i].rob, vecs[i].addr, vecs[i].data);
    for (int i = 0; i < 4; i++) commit(vecs[i].rob, 1'b1, vecs[i].expct);
    for (int i = 0; i < 4; i++) serve();
    check("table_empty", {31'd0, _sb_empty}, 32'd1);

    for (int i = 0; i < DEPTH; i++) alloc(5'(i), 2'b10);
    check("full_set", {31'd0, _sb_full}, 32'd1);
    check("full_not_empty", {31'd0, _sb_empty}, 32'd0);
    alloc(5'd20, 2'b10);
    check("full_hold", {31'd0, _sb_full}, 32'd1);
    fill(5'd0, 32'h400, 32'h1000);
    commit(5'd0, 1'b1, mk(5'd0));
    wait_req();
    tick();
    _mem_done = 1'b1; _alloc_valid = 1'b1; _alloc_rob_id = 5'd21; _alloc_width = 2'b10;
    tick();
    _mem_done = 1'b0; _alloc_valid = 1'b0;
    check("pop_frees_slot", {31'd0, _sb_full}, 32'd0);
    alloc(5'd22, 2'b10);
    check("refull", {31'd0, _sb_full}, 32'd1);
    for (int i = 1; i < DEPTH; i++) fill(5'(i), 32'h400 + 32'(4 * i), 32'h1000 + 32'(i));
    fill(5'd21, 32'h500, 32'h2100);
    fill(5'd22, 32'h600, 32'h2200);
    for (int i = 1; i < DEPTH; i++) commit(5'(i), 1'b1, mk(5'(i)));
    commit(5'd22, 1'b1, mk(5'd22));
    for (int i = 0; i < DEPTH; i++) serve();
    check("wrap_empty", {31'd0, _sb_empty}, 32'd1);

    alloc(5'd4, 2'b10);
    alloc(5'd5, 2'b01);
    fill(5'd5, 32'h704, 32'h55);
    fill(5'd4, 32'h700, 32'h44);
    commit(5'd5, 1'b0, mk(5'd5));
    repeat (3) tick();
    check("ooo_commit_ignored", {31'd0, _mem_req}, 32'd0);
    commit(5'd4, 1'b1, mk(5'd4));
    commit(5'd5, 1'b1, mk(5'd5));
    serve();
    serve();

    alloc(5'd1, 2'b10); alloc(5'd2, 2'b10); alloc(5'd3, 2'b10);
    fill(5'd1, 32'hA00, 32'h1111); fill(5'd2, 32'hA04, 32'h2222); fill(5'd3, 32'hA08, 32'h3333);
    commit(5'd1, 1'b1, mk(5'd1));
    _clear = 1'b1; _alloc_valid = 1'b1; _alloc_rob_id = 5'd9; _alloc_width = 2'b10;
    tick();
    _clear = 1'b0; _alloc_valid = 1'b0;
    check("clear_keeps_one", {31'd0, _sb_empty}, 32'd0);
    serve();
    check("clear_drained", {31'd0, _sb_empty}, 32'd1);
    commit(5'd2, 1'b0, mk(5'd2));
    repeat (8) tick();
    check("clear_no_write", {31'd0, _mem_req}, 32'd0);

    alloc(5'd6, 2'b10);
    fill(5'd6, 32'h800, 32'h66);
    commit(5'd6, 1'b1, mk(5'd6));
    wait_req();
    rdy_in = 1'b0; _mem_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_req", {31'd0, _mem_req}, 32'd1);
    end
    rdy_in = 1'b1; _mem_done = 1'b0;
    tick(); tick();
    check("freeze_still_busy", {31'd0, _mem_req}, 32'd1);
    _mem_done = 1'b1;
    tick();
    _mem_done = 1'b0;
    check("freeze_pop", {31'd0, _mem_req}, 32'd0);
    check("freeze_empty", {31'd0, _sb_empty}, 32'd1);

    alloc(5'd8, 2'b10);
    fill(5'd8, 32'h900, 32'h88);
    commit(5'd8, 1'b1, mk(5'd8));
    wait_req();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("busy_rst_req", {31'd0, _mem_req}, 32'd0);
    check("busy_rst_addr", _mem_addr, 32'd0);
    check("busy_rst_empty", {31'd0, _sb_empty}, 32'd1);

`ifdef STORE_FORWARD_EN
    alloc(5'd10, 2'b10);
    alloc(5'd11, 2'b10);
    fill(5'd10, 32'h200, 32'h11);
    fill(5'd11, 32'h200, 32'h22);
    _fwd_addr = 32'h202;
    #1;
    check("fwd_hit", {31'd0, _fwd_hit}, 32'd1);
    check("fwd_data", _fwd_data, 32'h22);
    _fwd_addr = 32'h300;
    #1;
    check("fwd_miss", {31'd0, _fwd_hit}, 32'd0);
    tick();
    _clear = 1'b1;
    tick();
    _clear = 1'b0;
`endif

    repeat (5) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning store-queue entry count (power of two, 2..32).
REQ-002 SHALL have ports clk_in  in  1  system clock; rst_in  in  1  reset, synchronous, active-high; rdy_in  in  1  pause when low.
REQ-003 SHALL have ports _clear  in  1  mispredict flush; _alloc_valid  in  1  dispatch allocates a store; _alloc_rob_id  in  5  its ROB id; _alloc_width  in  2  00 byte, 01 half, 10 word.
REQ-004 SHALL have ports _lsb_rs_ready  in  1  address/data strobe from the LSB reservation station; _lsb_rob_id  in  5; _lsb_st_value  in  32; _lsb_ptr_value  in  32 effective address.
REQ-005 SHALL have ports _commit_valid  in  1  ROB commits a store; _commit_rob_id  in  5.
REQ-006 SHALL have ports _mem_req  out  1; _mem_addr  out  32; _mem_data  out  32; _mem_width  out  2; _mem_done  in  1  memory write finished.
REQ-007 SHALL have ports _sb_full  out  1  count==DEPTH; _sb_empty  out  1  count==0.

Function
REQ-008 SHALL hold entries in a circular FIFO with head, commit and tail pointers, each wrapping modulo DEPTH; count held separately so full and empty are distinguishable when pointers are equal.
REQ-009 SHALL give each entry the state WAIT (allocated), FILLED (address and data captured) or COMMITTED.
REQ-010 SHALL, when _alloc_valid and not full, write entry[tail] in WAIT with its rob_id and width and advance tail; _alloc_valid while full SHALL be ignored.
REQ-011 SHALL, when _lsb_rs_ready, capture address and data into the WAIT entry whose rob_id equals _lsb_rob_id and mark it FILLED; no match SHALL have no effect.
REQ-012 SHALL, when _commit_valid and entry[commit] is FILLED with rob_id equal to _commit_rob_id, mark it COMMITTED and advance commit; any mismatch SHALL be ignored.
REQ-013 SHALL drain memory with FSM IDLE/BUSY: IDLE -> BUSY when entry[head] is COMMITTED, registering _mem_req=1 and address/data/width from entry[head] one cycle later; BUSY -> IDLE on _mem_done, popping head with _mem_req=0 the next cycle.
REQ-014 SHALL hold _mem_addr/_mem_data/_mem_width stable for the whole of BUSY.
REQ-015 SHALL accept allocation, fill, commit and pop in the same cycle; simultaneous alloc and pop SHALL leave count unchanged, and a pop SHALL free a slot only from the next cycle (_sb_full is registered state).
REQ-016 SHALL on _clear discard all non-COMMITTED entries (tail <= commit, count <= committed count) while keeping COMMITTED entries and any BUSY transfer; alloc/fill/commit in the same cycle as _clear SHALL be ignored.
REQ-017 SHALL freeze all state when rdy_in is low, including the FSM; _mem_done while rdy_in is low SHALL be ignored.
REQ-018 SHALL pass data unmodified; narrowing to _mem_width is the memory controller's job.

Reset
REQ-019 SHALL on rst_in at a clock edge clear head, commit, tail and count to 0, set every entry invalid, enter IDLE, and drive _mem_req=0, _mem_addr=0, _mem_data=0, _mem_width=0, _sb_full=0, _sb_empty=1.
REQ-020 SHALL on reset during BUSY abandon the transfer, with _mem_req low from the next cycle.

Configuration
REQ-021 SHALL, with STORE_FORWARD_EN defined, add ports _fwd_addr in 32, _fwd_hit out 1 and _fwd_data out 32; _fwd_hit SHALL be combinationally 1 when a FILLED or COMMITTED word-width entry has address[31:2] equal to _fwd_addr[31:2], and _fwd_data SHALL be the youngest such entry's data.
REQ-022 SHALL, without STORE_FORWARD_EN, omit these ports and all compare logic.

Verification
REQ-023 Alloc rob 3 word; fill addr 0x100 data 0xDEADBEEF; commit 3 -> _mem_req=1 addr 0x100 data 0xDEADBEEF width 10 held until _mem_done; _sb_empty=1 the cycle after.
REQ-024 16 allocs with no fill -> _sb_full=1; 17th alloc ignored; one pop -> accepted next cycle; pointers wrap correctly.
REQ-025 Alloc 1,2,3; fill all; commit 1; _clear -> count=1, entry 1 drains, 2 and 3 never reach memory.
REQ-026 Fill rob 5 before rob 4, commit 5 first -> ignored; commit 4 then 5 -> writes issue in order 4,5.
REQ-027 rdy_in low for 3 cycles during BUSY with _mem_done pulsed -> state frozen, pop only after rdy_in high and a new _mem_done.
REQ-028 STORE_FORWARD_EN: stores 0x200=0x11 then 0x200=0x22 filled; _fwd_addr 0x202 -> _fwd_hit=1, _fwd_data=0x22; 0x300 -> _fwd_hit=0.
